branch_resolve_unit: RTL

//  Update-side partner of the 2-bit branch history table: holds predictions made at fetch in program order and

---
 rtl/bru_pkg.sv | 30 +++
 rtl/bru_queue.sv | 72 +++++++
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bru_pkg
//  Purpose  : Shared constants and queue-entry layout for the branch resolve
//             unit. An entry is the state a prediction must carry until it is
//             resolved in EX.
//             Entry layout, MSB to LSB: {idx, taken, alt_pc}.
//  Revision : 1.0 - initial release
// ============================================================================
package bru_pkg;

   localparam int BRU_IDX_W    = 5;                 // BHT index width
   localparam int BRU_PC_W     = 32;                // PC width
   localparam int BRU_BHT_SIZE = 1 << BRU_IDX_W;    // BHT entries
   localparam int BRU_ENTRY_W  = BRU_IDX_W + 1 + BRU_PC_W;

   // Entry layout for the default widths.
   typedef struct packed {
      logic [BRU_IDX_W-1:0] idx;
      logic                 taken;
      logic [BRU_PC_W-1:0]  alt_pc;
   } bru_entry_t;

   // Entry width for arbitrary index/PC widths.
   function automatic int bru_entry_w(input int idx_w, input int pc_w);
      return idx_w + 1 + pc_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bru_queue.sv
`default_nettype none
// ============================================================================
//  Module   : bru_queue
//  Purpose  : DEPTH-entry in-order FIFO holding in-flight predictions.
//             clear has priority over push/pop. A push while full is taken
//             only when a pop happens in the same cycle.
//  Ports    : clk, arst        clock / async active-high reset
//             push, push_data  enqueue at tail
//             pop              dequeue head (ignored when empty)
//             clear            drop every entry
//             head_data        oldest entry (undefined when empty)
//             count            current entries, full, empty
//  Revision : 1.0 - initial release
// ============================================================================
module bru_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 38
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       clear,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int c_ptr_w = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head_data = r_mem[r_rd_ptr];

   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         r_count <= r_count + (c_ptr_w+1)'(w_do_push) - (c_ptr_w+1)'(w_do_pop);
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Update-side partner of the 2-bit BHT. Queues predictions from IF
//             in program order, retires the oldest against the EX outcome,
//             drives the BHT write port and raises a one-cycle mispredict
//             with the redirect PC. All outputs are registered.
//  Ports    : clk, arst                          clock / async reset
//             pred_valid/idx/taken/alt_pc, pred_ready   IF side
//             res_valid, res_taken, flush        EX / control side
//             upd_en, upd_addr, upd_taken        BHT write port
//             mispredict, redirect_pc            redirect
//             occupancy, br_count, mis_count, underflow   status
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = BRU_IDX_W,
   parameter int PC_W  = BRU_PC_W,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     pred_valid,
   input  logic [IDX_W-1:0]         pred_idx,
   input  logic                     pred_taken,
   input  logic [PC_W-1:0]          pred_alt_pc,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic                     flush,
   output logic                     upd_en,
   output logic [IDX_W-1:0]         upd_addr,
   output logic                     upd_taken,
   output logic                     mispredict,
   output logic [PC_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         br_count,
   output logic [CNT_W-1:0]         mis_count,
   output logic                     underflow
);

   localparam int c_entry_w = bru_entry_w(IDX_W, PC_W);

   logic [c_entry_w-1:0]   w_head;
   logic [IDX_W-1:0]       w_head_idx;
   logic                   w_head_taken;
   logic [PC_W-1:0]        w_head_alt_pc;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_res;
   logic                   w_mis;
   logic                   w_clear;
   logic                   w_pop;
   logic                   w_push;

   logic                   r_upd_en;
   logic [IDX_W-1:0]       r_upd_addr;
   logic                   r_upd_taken;
   logic                   r_mispredict;
   logic [PC_W-1:0]        r_redirect_pc;
   logic [CNT_W-1:0]       r_br_count;
   logic [CNT_W-1:0]       r_mis_count;
   logic                   r_underflow;

   assign w_head_idx    = w_head[c_entry_w-1 -: IDX_W];
   assign w_head_taken  = w_head[PC_W];
   assign w_head_alt_pc = w_head[PC_W-1:0];

   // A resolve only counts when there is something to resolve.
   assign w_res   = res_valid & ~w_empty;
   // An external flush supersedes the redirect: the outcome still trains the
   // BHT, but the front end is already being redirected elsewhere.
   assign w_mis   = w_res & (res_taken != w_head_taken) & ~flush;
   assign w_clear = flush | w_mis;
   assign w_pop   = w_res & ~w_clear;
   // pred_ready reflects only stored state; a push while full is still
   // honoured when a correct resolve frees the head in the same cycle.
   assign w_push  = pred_valid & (~w_full | w_pop) & ~w_clear;

   assign pred_ready = ~w_full;

   bru_queue #(
      .DEPTH (DEPTH),
      .WIDTH (c_entry_w)
   ) u_queue (
      .clk       (clk),
      .arst      (arst),
      .push      (w_push),
      .push_data ({pred_idx, pred_taken, pred_alt_pc}),
      .pop       (w_pop),
      .clear     (w_clear),
      .head_data (w_head),
      .count     (occupancy),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_upd_en      <= 1'b0;
         r_upd_addr    <= '0;
         r_upd_taken   <= 1'b0;
         r_mispredict  <= 1'b0;
         r_redirect_pc <= '0;
         r_br_count    <= '0;
         r_mis_count   <= '0;
         r_underflow   <= 1'b0;
      end else begin
         r_upd_en     <= w_res;
         r_mispredict <= w_mis;
         if (w_res) begin
            r_upd_addr  <= w_head_idx;
            r_upd_taken <= res_taken;
            r_br_count  <= r_br_count + CNT_W'(1);
         end
         if (w_mis) begin
            r_redirect_pc <= w_head_alt_pc;
            r_mis_count   <= r_mis_count + CNT_W'(1);
         end
         if (res_valid && w_empty) r_underflow <= 1'b1;
      end
   end

   assign upd_en      = r_upd_en;
   assign upd_addr    = r_upd_addr;
   assign upd_taken   = r_upd_taken;
   assign mispredict  = r_mispredict;
   assign redirect_pc = r_redirect_pc;
   assign br_count    = r_br_count;
   assign mis_count   = r_mis_count;
   assign underflow   = r_underflow;

endmodule
`default_nettype wire
